// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset release sequencer.
//   - seq_state_e  : sequencer FSM states
//   - ACK_TIMEOUT  : cycles to wait for a domain ready before flagging an error
//   - DEF_*        : default parameter values used by the top level
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int ACK_TIMEOUT    = 16;

    localparam int DEF_NUM_DOM    = 3;
    localparam int DEF_MIN_ASSERT = 8;
    localparam int DEF_GAP_CYC    = 4;
    localparam int DEF_CNT_W      = 4;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Request/status bundle between software control, downstream blocks and the
// reset sequencer.
//   SW_RST_REQ  : single-cycle software reset request
//   SW_RST_MASK : domains targeted by SW_RST_REQ
//   DOM_RST_N   : active-low reset per downstream block
//   SEQ_BUSY    : sequence in progress
//   SEQ_DONE    : one-cycle pulse on sequence completion
//   DOM_RDY / SEQ_ERR exist only when RST_SEQ_ACK_EN is defined.
// master = requester / consumer side, slave = sequencer.
interface rst_seq_ctrl_if #(
    parameter int NUM_DOM = 3
) ();
    logic               SW_RST_REQ;
    logic [NUM_DOM-1:0] SW_RST_MASK;
    logic [NUM_DOM-1:0] DOM_RST_N;
    logic               SEQ_BUSY;
    logic               SEQ_DONE;
`ifdef RST_SEQ_ACK_EN
    logic [NUM_DOM-1:0] DOM_RDY;
    logic               SEQ_ERR;

    modport master (
        output SW_RST_REQ, SW_RST_MASK, DOM_RDY,
        input  DOM_RST_N, SEQ_BUSY, SEQ_DONE, SEQ_ERR
    );
    modport slave (
        input  SW_RST_REQ, SW_RST_MASK, DOM_RDY,
        output DOM_RST_N, SEQ_BUSY, SEQ_DONE, SEQ_ERR
    );
`else
    modport master (
        output SW_RST_REQ, SW_RST_MASK,
        input  DOM_RST_N, SEQ_BUSY, SEQ_DONE
    );
    modport slave (
        input  SW_RST_REQ, SW_RST_MASK,
        output DOM_RST_N, SEQ_BUSY, SEQ_DONE
    );
`endif
endinterface

// File: rtl/rst_seq_pick.sv
// Combinational finder: lowest set bit of mask at index >= start.
//   mask  : candidate domains
//   start : lowest index to consider (may equal NUM_DOM, meaning none)
//   found : a qualifying bit exists
//   idx   : index of that bit (0 when none)
module rst_seq_pick #(
    parameter int NUM_DOM = 3,
    parameter int SW      = 2
) (
    input  logic [NUM_DOM-1:0] mask,
    input  logic [SW-1:0]      start,
    output logic               found,
    output logic [SW-1:0]      idx
);
    logic [NUM_DOM-1:0] elig;

    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_elig
            assign elig[gi] = mask[gi] && (int'(start) <= gi);
        end
    endgenerate

    assign found = |elig;

    // Scan downward so the last hit written is the lowest eligible index.
    always_comb begin
        idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (elig[i]) idx = SW'(i);
        end
    end
endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer. Holds targeted domain resets low for MIN_ASSERT
// cycles, then releases targeted domains in ascending order GAP_CYC cycles
// apart. Software may request partial re-sequencing by mask; requests that
// arrive while busy are accumulated and run straight after the current one.
// Ports:
//   CLK : clock
//   RST : synchronous active-high reset (forces full reset sequence)
//   bus : rst_seq_ctrl_if.slave (request, per-domain resets, busy/done)
// Optional: define RST_SEQ_ACK_EN to gate each release on DOM_RDY of the
// previously released domain, with a timeout that latches SEQ_ERR.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM    = DEF_NUM_DOM,
    parameter int MIN_ASSERT = DEF_MIN_ASSERT,
    parameter int GAP_CYC    = DEF_GAP_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic          CLK,
    input  logic          RST,
    rst_seq_ctrl_if.slave bus
);
    // Wide enough to hold NUM_DOM itself ("past the last domain").
    localparam int SW = $clog2(NUM_DOM + 1);

    seq_state_e         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [NUM_DOM-1:0] tgt_reg, tgt_next;
    logic [NUM_DOM-1:0] pend_reg, pend_next;
    logic [SW-1:0]      idx_reg, idx_next;
    logic [NUM_DOM-1:0] dom_reg, dom_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [NUM_DOM-1:0] req_mask, pend_merged;
    logic               req_hit;
    logic [SW-1:0]      cur_start, cur_idx;
    logic               cur_found, any_above;
    logic               hold_exp, gap_exp, ack_ok, release_now;

    assign req_mask    = bus.SW_RST_REQ ? bus.SW_RST_MASK : '0;
    assign req_hit     = |req_mask;
    assign pend_merged = pend_reg | req_mask;

    // HOLD releases the lowest target; GAP continues above the last one.
    assign cur_start = (state_reg == HOLD) ? '0 : idx_reg + SW'(1);

    rst_seq_pick #(.NUM_DOM(NUM_DOM), .SW(SW)) u_pick (
        .mask  (tgt_reg),
        .start (cur_start),
        .found (cur_found),
        .idx   (cur_idx)
    );

    // Any target left above the one being released decides GAP vs DONE.
    assign any_above = |((tgt_reg >> cur_idx) >> 1);
    assign hold_exp  = (cnt_reg == CNT_W'(MIN_ASSERT - 1));
    assign gap_exp   = (cnt_reg == CNT_W'(GAP_CYC - 1));

`ifdef RST_SEQ_ACK_EN
    logic [4:0] ack_cnt_reg;
    logic       err_reg;
    logic       rdy_seen, ack_to;

    assign rdy_seen = |(bus.DOM_RDY & (NUM_DOM'(1) << idx_reg));
    assign ack_to   = (ack_cnt_reg == 5'(ACK_TIMEOUT - 1));
    assign ack_ok   = rdy_seen || ack_to;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (release_now)
                ack_cnt_reg <= '0;
            else if (state_reg == GAP && !ack_to)
                ack_cnt_reg <= ack_cnt_reg + 5'd1;
            if (state_reg == GAP && ack_to && !rdy_seen)
                err_reg <= 1'b1;
        end
    end

    assign bus.SEQ_ERR = err_reg;
`else
    assign ack_ok = 1'b1;
`endif

    assign release_now = cur_found &&
                         ((state_reg == HOLD && hold_exp) ||
                          (state_reg == GAP && gap_exp && ack_ok));

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            tgt_reg   <= '1;
            pend_reg  <= '0;
            idx_reg   <= '0;
            dom_reg   <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tgt_reg   <= tgt_next;
            pend_reg  <= pend_next;
            idx_reg   <= idx_next;
            dom_reg   <= dom_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tgt_next   = tgt_reg;
        pend_next  = pend_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_hit) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                    tgt_next   = req_mask;
                end
            end
            HOLD, GAP: begin
                pend_next = pend_merged;
                if (release_now) begin
                    cnt_next   = '0;
                    idx_next   = cur_idx;
                    state_next = any_above ? GAP : DONE;
                end else if (!(state_reg == GAP && gap_exp)) begin
                    // GAP saturates while waiting for a domain ready.
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                pend_next = '0;
                cnt_next  = '0;
                if (|pend_merged) begin
                    state_next = HOLD;
                    tgt_next   = pend_merged;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        dom_next  = dom_reg;
        busy_next = busy_reg;
        done_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (req_hit) begin
                    dom_next  = dom_reg & ~req_mask;
                    busy_next = 1'b1;
                end
            end
            HOLD, GAP: begin
                if (release_now)
                    dom_next = dom_reg | (NUM_DOM'(1) << cur_idx);
            end
            DONE: begin
                done_next = 1'b1;
                busy_next = |pend_merged;
                dom_next  = dom_reg & ~pend_merged;
            end
            default: ;
        endcase
    end

    assign bus.DOM_RST_N = dom_reg;
    assign bus.SEQ_BUSY  = busy_reg;
    assign bus.SEQ_DONE  = done_reg;
endmodule
